elbeth_mux_n_to_1_pipe: RTL and testbench
=========================================

// Module: elbeth_mux_n_to_1_pipe
// PURPOSE
//  Parametrised N-to-1 select stage with a registered output and a valid/ready
//  handshake, for ELBETH pipeline operand/forwarding paths. Each accepted
//  transfer captures one input, chosen by bit_select, into a 2-entry skid
//  buffer so that downstream stalls never drop data. Out-of-range selects
//  produce a defined value and raise an error flag.
// PARAMETERS
//  WIDTH        32   data width of each input and of mux_out
//  NUM_IN       3    number of inputs, >= 2
//  SEL_W        2    bit_select width; must satisfy 2**SEL_W >= NUM_IN
//  DEFAULT_VAL  0    value captured when bit_select >= NUM_IN
// PORTS
//  clk          in   1             rising-edge clock
//  rst_n        in   1             asynchronous reset, active low
//  mux_in       in   NUM_IN*WIDTH  input k is mux_in[k*WIDTH +: WIDTH]
//  bit_select   in   SEL_W         input index, sampled on accept
//  in_valid     in   1             upstream offers mux_in/bit_select
//  in_ready     out  1             stage can accept this cycle
//  flush        in   1             synchronous discard of all held entries
//  mux_out      out  WIDTH         head entry data
//  out_valid    out  1             head entry valid
//  out_ready    in   1             downstream takes head this cycle
//  sel_err      out  1             sticky; set on an accepted out-of-range select
//  sel_err_clr  in   1             clears sel_err
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): both entries invalid, mux_out=0,
//    out_valid=0, in_ready=1, sel_err=0.
//  - accept = in_valid & in_ready; take = out_valid & out_ready.
//  - Captured value = input[bit_select] if bit_select < NUM_IN, else DEFAULT_VAL.
//  - Latency: data accepted at edge t appears on mux_out after edge t, when
//    the buffer was EMPTY. Throughput: 1 transfer per cycle while out_ready=1.
//  - in_ready is a register output: in_ready = !skid_valid. It never depends
//    combinationally on out_ready.
//  - Storage: head register (drives mux_out/out_valid) and skid register.
//  - States: EMPTY (no entries), ONE (head only), FULL (head + skid).
//    EMPTY: accept -> ONE.
//    ONE:   accept & take -> ONE (head <= new); accept & !take -> FULL;
//           !accept & take -> EMPTY; otherwise hold.
//    FULL:  in_ready=0; take -> ONE (head <= skid); else hold.
//  - Ordering is strict FIFO: the skid entry always leaves after the head.
//  - mux_out holds its last value while out_valid=0. It changes only on a load.
//  - flush=1: next state EMPTY, and any accept in the same cycle is discarded.
//    flush takes priority over accept and take. in_ready returns to 1 on the
//    next cycle.
//  - sel_err: set on the edge where an out-of-range select is accepted. Held
//    until sel_err_clr. If set and clear occur in the same cycle, set wins.
//    Flush does not clear sel_err.
//  - Reset asserted mid-transfer: all entries are dropped immediately. No
//    partial output.
// TESTING
//  1 Reset, then NUM_IN=3, in_valid=1 with sel=0,1,2 on mux_in = A,B,C and
//    out_ready=1 -> mux_out = A,B,C on consecutive cycles, 1-cycle latency.
//  2 sel=2'b11 accepted -> mux_out=DEFAULT_VAL(0) and sel_err=1. Pulse
//    sel_err_clr -> sel_err=0. Set and clear in the same cycle -> sel_err=1.
//  3 out_ready=0 while sending X then Y -> state FULL, in_ready=0, mux_out=X.
//    Raise out_ready -> X then Y delivered. Nothing lost or duplicated.
//  4 In FULL, assert flush with in_valid=1 -> next cycle out_valid=0,
//    in_ready=1, and the offered word never appears.
//  5 Drive rst_n low asynchronously mid-burst (FULL) -> out_valid=0 and
//    in_ready=1 immediately, before the next clk edge.
//  6 Random in_valid/out_ready over 10k cycles for WIDTH=8, NUM_IN=5 ->
//    scoreboard checks exact in-order delivery.

Source files
------------

// File: rtl/elbeth_mux_n_to_1_pipe.sv
// N-to-1 select stage with a 2-entry skid buffer and valid/ready handshake.
// Head register drives mux_out/out_valid; in_ready is registered.
module elbeth_mux_n_to_1_pipe #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      NUM_IN      = 3,
  parameter int unsigned      SEL_W       = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] mux_in,
  input  logic [SEL_W-1:0]        bit_select,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        mux_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    sel_err_clr
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] sel_val_c;
  logic             sel_oor_c;
  logic             accept_c;
  logic             take_c;
  logic             load_head_new;
  logic             load_head_skid;
  logic             load_skid;

  assign accept_c  = in_valid & in_ready;
  assign take_c    = out_valid & out_ready;
  assign sel_oor_c = (32'(bit_select) >= NUM_IN);

  // Input select; out-of-range indices fall through to DEFAULT_VAL
  always_comb begin
    sel_val_c = DEFAULT_VAL;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bit_select == SEL_W'(k)) sel_val_c = mux_in[k*WIDTH +: WIDTH];
    end
  end

  // State register plus registered handshake flags derived from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != ST_EMPTY);
      in_ready  <= (state_nxt != ST_FULL);
    end
  end

  // Next-state and load enables; flush overrides everything
  always_comb begin
    state_nxt      = state;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept_c) begin
          state_nxt     = ST_ONE;
          load_head_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept_c && take_c) begin
          load_head_new = 1'b1;
        end else if (accept_c) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (take_c) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (take_c) begin
          state_nxt      = ST_ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      state_nxt      = ST_EMPTY;
      load_head_new  = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Data registers: mux_out changes only when the head is loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_out <= '0;
      skid_q  <= '0;
    end else begin
      if (load_head_new)       mux_out <= sel_val_c;
      else if (load_head_skid) mux_out <= skid_q;
      if (load_skid)           skid_q  <= sel_val_c;
    end
  end

  // Sticky select error; a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (accept_c && sel_oor_c) begin
      sel_err <= 1'b1;
    end else if (sel_err_clr) begin
      sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_elbeth_mux_n_to_1_pipe.sv
// Bench: directed literal checks on a default-parameter instance, plus a
// randomized run on an 8-bit/5-input instance checked against a queue model.
module tb_elbeth_mux_n_to_1_pipe;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  // Instance A: WIDTH=32, NUM_IN=3, SEL_W=2, DEFAULT_VAL=0
  logic [95:0] a_in;
  logic [1:0]  a_sel;
  logic        a_iv, a_ir, a_fl, a_ov, a_or, a_err, a_clr;
  logic [31:0] a_out;

  // Instance B: WIDTH=8, NUM_IN=5, SEL_W=3, DEFAULT_VAL=8'h5A
  logic [39:0] b_in;
  logic [2:0]  b_sel;
  logic        b_iv, b_ir, b_fl, b_ov, b_or, b_err, b_clr;
  logic [7:0]  b_out;

  elbeth_mux_n_to_1_pipe dut_a (
    .clk(clk), .rst_n(rst_n), .mux_in(a_in), .bit_select(a_sel),
    .in_valid(a_iv), .in_ready(a_ir), .flush(a_fl), .mux_out(a_out),
    .out_valid(a_ov), .out_ready(a_or), .sel_err(a_err), .sel_err_clr(a_clr)
  );

  elbeth_mux_n_to_1_pipe #(
    .WIDTH(8), .NUM_IN(5), .SEL_W(3), .DEFAULT_VAL(8'h5A)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .mux_in(b_in), .bit_select(b_sel),
    .in_valid(b_iv), .in_ready(b_ir), .flush(b_fl), .mux_out(b_out),
    .out_valid(b_ov), .out_ready(b_or), .sel_err(b_err), .sel_err_clr(b_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model for instance B: a FIFO of capacity two
  logic [7:0] mq[$];
  logic [7:0] m_last;
  logic       m_err;

  function automatic logic [7:0] b_pick(input logic [39:0] din, input logic [2:0] s);
    if (int'(s) < 5) return din[int'(s)*8 +: 8];
    return 8'h5A;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit acc;
    bit tk;
    if (!rst_n) begin
      mq.delete();
      m_last = 8'h00;
      m_err  = 1'b0;
    end else begin
      acc = b_iv && (mq.size() < 2);
      tk  = (mq.size() > 0) && b_or;
      if (b_fl) begin
        mq.delete();
      end else begin
        if (tk)  void'(mq.pop_front());
        if (acc) mq.push_back(b_pick(b_in, b_sel));
        if (mq.size() > 0) m_last = mq[0];
      end
      if (acc && int'(b_sel) >= 5) m_err = 1'b1;
      else if (b_clr)              m_err = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("b_out_valid", 64'(b_ov), 64'(mq.size() > 0));
      chk("b_in_ready", 64'(b_ir), 64'(mq.size() < 2));
      chk("b_mux_out", 64'(b_out), 64'(m_last));
      chk("b_sel_err", 64'(b_err), 64'(m_err));
    end
  end

  localparam logic [31:0] VA = 32'hA0A0_0001;
  localparam logic [31:0] VB = 32'hB0B0_0002;
  localparam logic [31:0] VC = 32'hC0C0_0003;

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    a_in = '0; a_sel = '0; a_iv = 0; a_fl = 0; a_or = 0; a_clr = 0;
    b_in = '0; b_sel = '0; b_iv = 0; b_fl = 0; b_or = 0; b_clr = 0;
    #23 rst_n = 1'b1;
    step();
    chk("rst_out_valid", 64'(a_ov), 64'd0);
    chk("rst_in_ready", 64'(a_ir), 64'd1);
    chk("rst_mux_out", 64'(a_out), 64'd0);
    chk("rst_sel_err", 64'(a_err), 64'd0);

    // Back-to-back transfers, 1-cycle latency
    a_in = {VC, VB, VA}; a_or = 1; a_iv = 1; a_sel = 2'd0;
    step(); chk("t1_a", 64'(a_out), 64'(VA)); chk("t1_a_valid", 64'(a_ov), 64'd1);
    a_sel = 2'd1;
    step(); chk("t1_b", 64'(a_out), 64'(VB));
    a_sel = 2'd2;
    step(); chk("t1_c", 64'(a_out), 64'(VC)); chk("t1_c_ready", 64'(a_ir), 64'd1);
    a_iv = 0;
    step(); chk("t1_drain", 64'(a_ov), 64'd0); chk("t1_hold", 64'(a_out), 64'(VC));

    // Out-of-range select, sticky error, set-wins-over-clear
    a_iv = 1; a_sel = 2'd3;
    step(); chk("t2_default", 64'(a_out), 64'd0); chk("t2_err", 64'(a_err), 64'd1);
    a_iv = 0;
    step(); chk("t2_sticky", 64'(a_err), 64'd1);
    a_clr = 1;
    step(); chk("t2_clr", 64'(a_err), 64'd0);
    a_iv = 1; a_sel = 2'd3;
    step(); chk("t2_set_wins", 64'(a_err), 64'd1);
    a_iv = 0;
    step(); chk("t2_cleared", 64'(a_err), 64'd0);
    a_clr = 0;

    // Stall: X then Y held, then drained in order
    a_or = 0; a_iv = 1; a_sel = 2'd0;
    step(); chk("t3_one_ready", 64'(a_ir), 64'd1);
    a_sel = 2'd1;
    step(); chk("t3_full_ready", 64'(a_ir), 64'd0); chk("t3_head_x", 64'(a_out), 64'(VA));
    a_iv = 0;
    step(); chk("t3_full_hold", 64'(a_out), 64'(VA)); chk("t3_full_valid", 64'(a_ov), 64'd1);
    a_or = 1;
    step(); chk("t3_y", 64'(a_out), 64'(VB)); chk("t3_y_ready", 64'(a_ir), 64'd1);
    step(); chk("t3_empty", 64'(a_ov), 64'd0); chk("t3_last", 64'(a_out), 64'(VB));

    // Flush in FULL discards held entries and the offered word
    a_or = 0; a_iv = 1; a_sel = 2'd0;
    step();
    a_sel = 2'd1;
    step();
    a_sel = 2'd2; a_fl = 1;
    step(); chk("t4_valid", 64'(a_ov), 64'd0); chk("t4_ready", 64'(a_ir), 64'd1);
    chk("t4_hold", 64'(a_out), 64'(VA));
    a_fl = 0; a_iv = 0; a_or = 1;
    step(); chk("t4_nothing", 64'(a_ov), 64'd0);
    step(); chk("t4_nothing2", 64'(a_out), 64'(VA));

    // Asynchronous reset while FULL
    a_or = 0; a_iv = 1; a_sel = 2'd2;
    step();
    step(); chk("t5_full", 64'(a_ir), 64'd0);
    a_iv = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", 64'(a_ov), 64'd0);
    chk("t5_ready", 64'(a_ir), 64'd1);
    chk("t5_out", 64'(a_out), 64'd0);
    #4 rst_n = 1'b1;
    step(); chk("t5_after", 64'(a_ov), 64'd0);

    // Randomized traffic on instance B
    for (int i = 0; i < 10000; i++) begin
      b_in  = {$urandom, $urandom};
      b_sel = 3'($urandom_range(0, 7));
      b_iv  = ($urandom % 4) != 0;
      b_or  = (i % 400 < 200) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
      b_clr = ($urandom % 16) == 0;
      b_fl  = ($urandom % 97) == 0;
      if (b_fl) b_iv = 1'b0;
      step();
    end
    b_iv = 0; b_or = 1; b_fl = 0; b_clr = 0;
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
